// File: rtl/alu_op_sched_pkg.sv
// Shared definitions for the ALU op scheduler: opcode width, the illegal
// opcode and the scheduler FSM state encodings.
// Imported by the top and by the interface users; contains no logic.
package alu_op_sched_pkg;

  localparam int OP_W = 4;

  // Opcode 0 is reserved as illegal; every other opcode selects a function unit.
  localparam logic [OP_W-1:0] OP_NOP = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_op_sched_if.sv
// Bundle of requester-side and ALU-side signals of the op scheduler.
// slave: the scheduler (takes requests and ALU result, drives grant/done/decoder).
// master: requesters plus ALU model (drive requests and result, observe the rest).
interface alu_op_sched_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) ();

  logic [N_REQ-1:0]        req_in;
  logic [4*N_REQ-1:0]      op_in;
  logic [DATA_W*N_REQ-1:0] a_in;
  logic [DATA_W*N_REQ-1:0] b_in;
  logic [DATA_W-1:0]       alu_res_in;
  logic [N_REQ-1:0]        gnt_out;
  logic [N_REQ-1:0]        done_out;
  logic [DATA_W-1:0]       result_out;
  logic                    err_out;
  logic [3:0]              dec_sel_out;
  logic                    dec_en_n_out;
  logic [DATA_W-1:0]       alu_a_out;
  logic [DATA_W-1:0]       alu_b_out;
  logic                    busy_out;

  modport slave (
    input  req_in, op_in, a_in, b_in, alu_res_in,
    output gnt_out, done_out, result_out, err_out,
           dec_sel_out, dec_en_n_out, alu_a_out, alu_b_out, busy_out
  );

  modport master (
    output req_in, op_in, a_in, b_in, alu_res_in,
    input  gnt_out, done_out, result_out, err_out,
           dec_sel_out, dec_en_n_out, alu_a_out, alu_b_out, busy_out
  );

endinterface

// File: rtl/alu_op_sched_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping around.
// Latency: purely combinational. Backpressure: none, caller decides when to use the pick.
// Ports: req (levels), ptr (priority start) -> gnt_oh (one-hot), gnt_idx, gnt_vld.
module alu_op_sched_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  int cand;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = 0;
    // Scan from the farthest offset down so the nearest-to-ptr request wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
    if (gnt_vld) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_sched.sv
// Shares one ALU (op decoder + function units) between N_REQ requesters, round robin.
// Latency: grant 1 cycle after request, done ALU_LAT+1 cycles after request; issue period ALU_LAT+2.
// Backpressure: requests are levels held until grant; only one op in flight, others wait in IDLE.
// Ports: clk_in, rst_in (sync, active high), bus (slave modport: requests/operands/ALU
// result in; grant/done/result/err and decoder select/enable/operands/busy out, all registered).
module alu_op_sched
  import alu_op_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int ALU_LAT = 2
) (
  input  logic           clk_in,
  input  logic           rst_in,
  alu_op_sched_if.slave  bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   widx_q, widx_d;
  logic [N_REQ-1:0]   woh_q, woh_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;

  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic               err_q, err_d;
  logic [OP_W-1:0]    sel_q, sel_d;
  logic               en_n_q, en_n_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic               busy_q, busy_d;

  logic [N_REQ-1:0]   win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               win_vld;
  logic [OP_W-1:0]    win_op;
  logic [DATA_W-1:0]  win_a, win_b;

  alu_op_sched_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (bus.req_in),
    .ptr     (ptr_q),
    .gnt_oh  (win_oh),
    .gnt_idx (win_idx),
    .gnt_vld (win_vld)
  );

  // Select the winner's opcode and operands from the flat input buses.
  always_comb begin
    win_op = '0;
    win_a  = '0;
    win_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_op = bus.op_in[i*OP_W +: OP_W];
        win_a  = bus.a_in[i*DATA_W +: DATA_W];
        win_b  = bus.b_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next state and next output values. Outputs are registered, so each branch
  // sets what must be visible in the cycle of the state being entered.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    widx_d  = widx_q;
    woh_d   = woh_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    done_d  = '0;
    res_d   = '0;
    err_d   = 1'b0;
    sel_d   = sel_q;
    en_n_d  = en_n_q;
    a_d     = a_q;
    b_d     = b_q;

    unique case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          widx_d = win_idx;
          woh_d  = win_oh;
          gnt_d  = win_oh;
          if (win_op == OP_NOP) begin
            // Illegal op: grant and done in the same cycle, decoder untouched.
            state_d = ST_DONE;
            done_d  = win_oh;
            err_d   = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            en_n_d  = 1'b0;
            sel_d   = win_op;
            a_d     = win_a;
            b_d     = win_b;
            cnt_d   = LAT_W'(ALU_LAT - 1);
          end
        end
      end

      // ISSUE is the first enabled cycle, WAIT the remaining ones; the
      // counter tells how many enabled cycles are still to come.
      ST_ISSUE, ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          done_d  = woh_q;
          res_d   = bus.alu_res_in;
          en_n_d  = 1'b1;
          sel_d   = '0;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q - LAT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = (widx_q == IDX_W'(N_REQ - 1)) ? '0 : widx_q + IDX_W'(1);
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      widx_q  <= '0;
      woh_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      en_n_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      widx_q  <= widx_d;
      woh_q   <= woh_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      res_q   <= res_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      en_n_q  <= en_n_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt_out      = gnt_q;
  assign bus.done_out     = done_q;
  assign bus.result_out   = res_q;
  assign bus.err_out      = err_q;
  assign bus.dec_sel_out  = sel_q;
  assign bus.dec_en_n_out = en_n_q;
  assign bus.alu_a_out    = a_q;
  assign bus.alu_b_out    = b_q;
  assign bus.busy_out     = busy_q;

endmodule

// File: tb/tb_alu_op_sched.sv
// Bench for alu_op_sched: directed steps followed by randomized transactions
// checked against a transaction-level round-robin model.
module tb_alu_op_sched;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LAT = 2;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  alu_op_sched_if #(.N_REQ(N), .DATA_W(W)) bus ();

  alu_op_sched #(.N_REQ(N), .DATA_W(W), .ALU_LAT(LAT)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  int mptr     = 0;   // model round-robin pointer

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    bus.op_in[i*4 +: 4] = op;
    bus.a_in[i*W +: W]  = a;
    bus.b_in[i*W +: W]  = b;
  endtask

  // Round robin: first requester at or after ptr, wrapping; -1 if none.
  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  initial begin
    int g_idx[$];
    int g_cyc[$];
    logic [N-1:0]   rq;
    logic [3:0]     ops [N];
    logic [W-1:0]   as  [N];
    logic [W-1:0]   bs  [N];
    logic [W-1:0]   r;
    int w;
    int exp_order [5];

    rst_in         = 1'b1;
    bus.req_in     = '0;
    bus.op_in      = '0;
    bus.a_in       = '0;
    bus.b_in       = '0;
    bus.alu_res_in = '0;

    // Reset held two cycles.
    tick(); tick();
    chk("rst_en_n", bus.dec_en_n_out, 1);
    chk("rst_gnt",  bus.gnt_out, 0);
    chk("rst_done", bus.done_out, 0);
    chk("rst_res",  bus.result_out, 0);
    chk("rst_err",  bus.err_out, 0);
    chk("rst_sel",  bus.dec_sel_out, 0);
    chk("rst_a",    bus.alu_a_out, 0);
    chk("rst_b",    bus.alu_b_out, 0);
    chk("rst_busy", bus.busy_out, 0);
    rst_in = 1'b0;

    // Single request from requester 1, with operand A changed after grant.
    set_req(1, 4'h5, 8'h12, 8'h34);
    bus.alu_res_in = 8'h46;
    bus.req_in     = 4'b0010;
    tick();
    chk("s_gnt",  bus.gnt_out, 4'b0010);
    chk("s_en1",  bus.dec_en_n_out, 0);
    chk("s_sel1", bus.dec_sel_out, 5);
    chk("s_a1",   bus.alu_a_out, 8'h12);
    chk("s_b1",   bus.alu_b_out, 8'h34);
    chk("s_busy", bus.busy_out, 1);
    bus.req_in = '0;
    bus.a_in[1*W +: W] = 8'hAA;
    tick();
    chk("s_en2",   bus.dec_en_n_out, 0);
    chk("s_sel2",  bus.dec_sel_out, 5);
    chk("s_a_held", bus.alu_a_out, 8'h12);
    chk("s_gnt2",  bus.gnt_out, 0);
    chk("s_done2", bus.done_out, 0);
    tick();
    chk("s_done", bus.done_out, 4'b0010);
    chk("s_res",  bus.result_out, 8'h46);
    chk("s_err",  bus.err_out, 0);
    chk("s_en3",  bus.dec_en_n_out, 1);
    chk("s_sel3", bus.dec_sel_out, 0);
    tick();
    chk("s_idle", bus.busy_out, 0);
    mptr = 2;

    // Illegal opcode from requester 0.
    set_req(0, 4'h0, 8'h01, 8'h02);
    bus.req_in = 4'b0001;
    tick();
    chk("il_gnt",  bus.gnt_out, 4'b0001);
    chk("il_done", bus.done_out, 4'b0001);
    chk("il_err",  bus.err_out, 1);
    chk("il_res",  bus.result_out, 0);
    chk("il_en",   bus.dec_en_n_out, 1);
    bus.req_in = '0;
    tick();
    chk("il_idle", bus.busy_out, 0);
    chk("il_en2",  bus.dec_en_n_out, 1);
    mptr = 1;

    // Reset while requester 2 is in its wait cycle.
    set_req(2, 4'h3, 8'h21, 8'h22);
    bus.req_in = 4'b0100;
    tick();
    chk("rw_gnt", bus.gnt_out, 4'b0100);
    bus.req_in = '0;
    tick();
    rst_in = 1'b1;
    tick();
    chk("rw_done", bus.done_out, 0);
    chk("rw_en",   bus.dec_en_n_out, 1);
    chk("rw_busy", bus.busy_out, 0);
    rst_in = 1'b0;
    tick();
    chk("rw_done2", bus.done_out, 0);
    // Pointer is back at 0, so requester 0 beats requester 3.
    set_req(0, 4'h7, 8'h31, 8'h32);
    set_req(3, 4'h8, 8'h41, 8'h42);
    bus.req_in = 4'b1001;
    tick();
    chk("rw_ptr0", bus.gnt_out, 4'b0001);
    bus.req_in = '0;
    tick(); tick();
    chk("rw_done0", bus.done_out, 4'b0001);
    tick();
    mptr = 1;

    // All four requesting continuously from pointer 0.
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    mptr = 0;
    for (int i = 0; i < N; i++) set_req(i, 4'(i + 1), 8'(i), 8'(i + 8));
    bus.req_in = 4'b1111;
    for (int c = 1; c <= 18; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (bus.gnt_out[i]) begin
          g_idx.push_back(i);
          g_cyc.push_back(c);
        end
      end
    end
    bus.req_in = '0;
    tick(); tick();
    exp_order = '{0, 1, 2, 3, 0};
    chk("rr_count", g_idx.size(), 5);
    for (int k = 0; k < 5 && k < g_idx.size(); k++) begin
      chk($sformatf("rr_idx%0d", k), g_idx[k], exp_order[k]);
      chk($sformatf("rr_cyc%0d", k), g_cyc[k], 1 + k * (LAT + 2));
    end
    chk("rr_idle", bus.busy_out, 0);
    mptr = 1;

    // Randomized transactions.
    for (int t = 0; t < 60; t++) begin
      rq = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        ops[i] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        as[i]  = W'($urandom);
        bs[i]  = W'($urandom);
        set_req(i, ops[i], as[i], bs[i]);
      end
      bus.req_in = rq;
      w = pick(rq, mptr);
      tick();
      bus.req_in = '0;
      // Post-grant input changes must not reach the ALU.
      bus.a_in = W*N'({$urandom, $urandom});
      bus.b_in = W*N'({$urandom, $urandom});
      if (w < 0) begin
        chk("r_nogrant", bus.gnt_out, 0);
        chk("r_nobusy",  bus.busy_out, 0);
      end else if (ops[w] == 4'h0) begin
        chk("r_il_gnt",  bus.gnt_out, 32'(1 << w));
        chk("r_il_done", bus.done_out, 32'(1 << w));
        chk("r_il_err",  bus.err_out, 1);
        chk("r_il_res",  bus.result_out, 0);
        chk("r_il_en",   bus.dec_en_n_out, 1);
        tick();
        chk("r_il_idle", bus.busy_out, 0);
        mptr = (w + 1) % N;
      end else begin
        chk("r_gnt",  bus.gnt_out, 32'(1 << w));
        chk("r_en",   bus.dec_en_n_out, 0);
        chk("r_sel",  bus.dec_sel_out, ops[w]);
        chk("r_a",    bus.alu_a_out, as[w]);
        chk("r_b",    bus.alu_b_out, bs[w]);
        r = '0;
        for (int c = 1; c <= LAT; c++) begin
          if (c > 1) begin
            chk("r_en_hold",  bus.dec_en_n_out, 0);
            chk("r_sel_hold", bus.dec_sel_out, ops[w]);
            chk("r_a_hold",   bus.alu_a_out, as[w]);
            chk("r_gnt_once", bus.gnt_out, 0);
          end
          r = W'($urandom);
          bus.alu_res_in = r;
          tick();
        end
        chk("r_done", bus.done_out, 32'(1 << w));
        chk("r_res",  bus.result_out, r);
        chk("r_err",  bus.err_out, 0);
        chk("r_en_off", bus.dec_en_n_out, 1);
        chk("r_sel_off", bus.dec_sel_out, 0);
        tick();
        chk("r_idle", bus.busy_out, 0);
        chk("r_done_pulse", bus.done_out, 0);
        mptr = (w + 1) % N;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
